mul_share_arb: RTL and testbench
================================

# mul_share_arb

Round-robin arbiter and sequencer that shares one pipelined unsigned 13x14 -> 27-bit multiplier (the `Processing_HW_mul_mul_13ns_14ns_27_4_1` instance) among `N_REQ` requesters. It accepts operand pairs through per-requester valid/ready ports and issues at most one product per cycle into the multiplier. It tracks requester IDs through the multiplier latency with a tag pipeline, and returns results on one shared response port with backpressure. Backpressure is applied by gating the multiplier `ce`. It sits between the Processing_HW compute units and the shared DSP multiplier.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, requester ID width, equal to clog2(`N_REQ`).
- `A_W`, 13, operand A width (unsigned).
- `B_W`, 14, operand B width (unsigned).
- `P_W`, 27, product width, equal to `A_W`+`B_W`.
- `MUL_LAT`, 3, number of ce-enabled clock edges from operands at `mul_din0`/`mul_din1` to the product at `mul_dout`.

- `clk` in 1 : single clock, rising edge.
- `reset` in 1 : asynchronous, active-low reset.
- `req_valid` in `N_REQ` : per-requester operand valid.
- `req_ready` out `N_REQ` : per-requester accept, one-hot or zero.
- `req_a` in `N_REQ`*`A_W` : packed A operands; requester i occupies bits [i*A_W +: A_W].
- `req_b` in `N_REQ`*`B_W` : packed B operands, same packing.
- `rsp_valid` out 1 : result valid.
- `rsp_ready` in 1 : result accept.
- `rsp_id` out `ID_W` : requester that owns `rsp_data`.
- `rsp_data` out `P_W` : product.
- `mul_ce` out 1 : drives the multiplier `ce`.
- `mul_din0` out `A_W` : drives the multiplier `din0`.
- `mul_din1` out `B_W` : drives the multiplier `din1`.
- `mul_dout` in `P_W` : multiplier `dout`.
- `busy` out 1 : at least one operation in flight.

## Operation
- Stall rule: `mul_ce` = !(`rsp_valid` && !`rsp_ready`). It depends only on the response side and never on `req_valid`.
- Grant selection (combinational, only when `mul_ce`=1):
  - The search starts at pointer `rr_ptr`, wraps modulo `N_REQ`, and picks the first i with `req_valid[i]`=1.
  - The winner gets `req_ready[i]`=1; all other bits are 0. When `mul_ce`=0, `req_ready` is 0.
- Operand mux: `mul_din0`/`mul_din1` = `req_a`/`req_b` slice of the winner. With no winner, the value is don't-care; the bench only checks it when a grant is active.
- Pointer update: on a granted edge, `rr_ptr` <= winner+1 mod `N_REQ`. Otherwise `rr_ptr` holds.
- Tag pipeline: `vld[0..MUL_LAT-1]` and `tag[0..MUL_LAT-1]`. It shifts only on edges where `mul_ce`=1.
  - `vld[0]` <= grant present.
  - `tag[0]` <= winner ID.
  - Stage k <= stage k-1.
- Response: `rsp_valid` = `vld[MUL_LAT-1]`, `rsp_id` = `tag[MUL_LAT-1]`, `rsp_data` = `mul_dout`. There is no extra register: the multiplier holds `p` while `ce`=0, so `rsp_data` stays stable during a stall.
- `busy` = OR of all `vld` bits.
- Arithmetic: `rsp_data` = zero-extended A × zero-extended B, exact. The maximum result, 8191×16383 = 134193153, fits in 27 bits with no overflow or truncation.
- Reset (asynchronous assert, deassert synchronous to `clk` externally):
  - `vld` = 0, `tag` = 0, `rr_ptr` = 0.
  - Resulting output values: `rsp_valid`=0, `rsp_id`=0, `busy`=0, `mul_ce`=1. `req_ready` reflects only the current `req_valid`.
  - Operations in flight are discarded with no response. Multiplier data registers are not reset; stale `p` is masked because `vld`=0.

## Timing
- Latency: a request accepted in cycle t (`req_valid`&`req_ready` high at edge t) has `rsp_valid`=1 in cycle t+`MUL_LAT`, provided there were no stalls. Each stall cycle adds one cycle.
- Throughput: one accept per cycle while `rsp_ready`=1. Full pipeline occupancy is `MUL_LAT`.
- Handshake: a requester keeps `req_valid` and its operands stable until it sees `req_ready`. Requests are never dropped or reordered. Responses return in grant order.
- Stall: in every cycle where `rsp_valid`=1 and `rsp_ready`=0:
  - No new request is accepted.
  - The tag pipeline and multiplier are frozen.
  - `rsp_valid`, `rsp_id` and `rsp_data` are held.
- Simultaneous accept and response: a response handshake and a new grant occur on the same edge (`mul_ce`=1).
- Bubbles: a cycle with no winner inserts `vld`=0. Bubbles do not block later stages.
- Fairness: with all `N_REQ` requesters continuously valid and no stalls, each is granted exactly once every `N_REQ` cycles.

## Test plan
- Single op: reset, then requester 2 sends A=100, B=200 -> `req_ready[2]`=1 in the same cycle; `rsp_valid`=1 three cycles later with `rsp_id`=2 and `rsp_data`=20000; `busy` falls after the handshake.
- Max operands: A=8191, B=16383 from requester 0 -> `rsp_data`=134193153, with no wrap.
- Round robin: all 4 requesters valid continuously, A=i+1, B=10 -> grant order 0,1,2,3,0,…; responses 10,20,30,40 in that order, one per cycle.
- Backpressure: 3 ops in flight, `rsp_ready`=0 for 5 cycles ->
  - `mul_ce`=0 and `req_ready`=0 throughout.
  - First response held stable throughout.
  - After release, all 3 results arrive on consecutive cycles, unchanged.
- Reset mid-operation: assert `reset`=0 with 2 ops in flight -> `rsp_valid` and `busy` go 0 immediately (asynchronously); no stale response appears after release; the next grant starts at requester 0.
- Sparse traffic: requester 3 is valid every 4th cycle and the others are idle -> each op is granted on arrival, and its response arrives exactly 3 cycles later with `rsp_id`=3.

Source files
------------

// File: rtl/mul_share_arb_if.sv
// Handshake and multiplier-side bundle for the shared multiplier arbiter.
// slave is the arbiter's view; master is the environment's view.
interface mul_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int A_W   = 13,
    parameter int B_W   = 14,
    parameter int P_W   = 27
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [P_W-1:0]       rsp_data;
    logic                 mul_ce;
    logic [A_W-1:0]       mul_din0;
    logic [B_W-1:0]       mul_din1;
    logic [P_W-1:0]       mul_dout;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_dout,
        output req_ready, rsp_valid, rsp_id, rsp_data, mul_ce, mul_din0, mul_din1, busy
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_dout,
        input  req_ready, rsp_valid, rsp_id, rsp_data, mul_ce, mul_din0, mul_din1, busy
    );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one pipelined 13x14 multiplier among N_REQ requesters,
// with a tag pipeline that follows the multiplier latency and freezes with its ce.

module mul_share_arb_lane #(
    parameter int ID_W = 2,
    parameter int A_W  = 13,
    parameter int B_W  = 14,
    parameter int LANE = 0
) (
    input  logic            grant,
    input  logic [ID_W-1:0] win_id,
    input  logic [A_W-1:0]  a,
    input  logic [B_W-1:0]  b,
    output logic            ready,
    output logic [A_W-1:0]  a_sel,
    output logic [B_W-1:0]  b_sel
);
    // Non-winning lanes contribute zero so the operand mux is a plain OR tree.
    assign ready = grant && (win_id == ID_W'(LANE));
    assign a_sel = ready ? a : '0;
    assign b_sel = ready ? b : '0;
endmodule

module mul_share_arb #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 13,
    parameter int B_W     = 14,
    parameter int P_W     = 27,
    parameter int MUL_LAT = 3
) (
    input  logic           clk,
    input  logic           reset,
    mul_share_arb_if.slave bus
);
    localparam int SW = ID_W + 1;

    logic [MUL_LAT-1:0]           vld_pipe;
    logic [MUL_LAT-1:0][ID_W-1:0] tag_pipe;
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              win_id;
    logic                         win_found;
    logic                         grant;
    logic                         stall;
    logic [SW-1:0]                sum;
    logic [N_REQ-1:0]             ready_vec;
    logic [N_REQ-1:0][A_W-1:0]    a_sel;
    logic [N_REQ-1:0][B_W-1:0]    b_sel;
    logic [A_W-1:0]               din0;
    logic [B_W-1:0]               din1;

    // Only an unaccepted response can hold the pipe; request traffic never does.
    assign stall      = vld_pipe[MUL_LAT-1] && !bus.rsp_ready;
    assign bus.mul_ce = !stall;
    assign grant      = win_found && !stall;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, rr_ptr} + SW'(off);
            if (sum >= SW'(N_REQ))
                sum = sum - SW'(N_REQ);
            if (!win_found && bus.req_valid[sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = sum[ID_W-1:0];
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < N_REQ; i++) begin : g_lane
            mul_share_arb_lane #(
                .ID_W (ID_W),
                .A_W  (A_W),
                .B_W  (B_W),
                .LANE (i)
            ) u_lane (
                .grant  (grant),
                .win_id (win_id),
                .a      (bus.req_a[i*A_W +: A_W]),
                .b      (bus.req_b[i*B_W +: B_W]),
                .ready  (ready_vec[i]),
                .a_sel  (a_sel[i]),
                .b_sel  (b_sel[i])
            );
        end
    endgenerate

    always_comb begin
        din0 = '0;
        din1 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            din0 = din0 | a_sel[k];
            din1 = din1 | b_sel[k];
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.mul_din0  = din0;
    assign bus.mul_din1  = din1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            rr_ptr   <= '0;
        end else if (bus.mul_ce) begin
            vld_pipe[0] <= grant;
            tag_pipe[0] <= win_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
            if (grant)
                rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // The multiplier holds its output while ce is low, so data needs no local register.
    assign bus.rsp_valid = vld_pipe[MUL_LAT-1];
    assign bus.rsp_id    = tag_pipe[MUL_LAT-1];
    assign bus.rsp_data  = bus.mul_dout;
    assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: directed scenarios plus random traffic, checked each
// cycle against a queue-of-operations reference model and a ce-gated multiplier.
module tb_mul_share_arb;
    localparam int N = 4, IDW = 2, AW = 13, BW = 14, PW = 27, LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_share_arb_if #(.N_REQ(N), .ID_W(IDW), .A_W(AW), .B_W(BW), .P_W(PW)) bus ();

    mul_share_arb #(.N_REQ(N), .ID_W(IDW), .A_W(AW), .B_W(BW), .P_W(PW), .MUL_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Shared multiplier: LAT ce-enabled stages, data registers never reset.
    logic [PW-1:0] mp [LAT];
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            mp[0] <= PW'(bus.mul_din0) * PW'(bus.mul_din1);
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign bus.mul_dout = mp[LAT-1];

    typedef struct { int id; int p; int age; } op_t;
    typedef struct { int id; int p; int at; } log_t;

    op_t  q[$];
    log_t rsp_log[$];
    int   gnt_log[$];
    int   gnt_cyc[$];
    bit   pend [N];
    int   opa  [N];
    int   opb  [N];
    int   ptr = 0;
    int   cyc = 0;
    int   stalls = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = pend[i];
            bus.req_a[i*AW +: AW]   = AW'(opa[i]);
            bus.req_b[i*BW +: BW]   = BW'(opb[i]);
        end
    endtask

    task automatic offer(input int i, input int a, input int b);
        if (!pend[i]) begin
            pend[i] = 1'b1;
            opa[i]  = a;
            opb[i]  = b;
        end
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        gnt_log.delete();
        gnt_cyc.delete();
    endtask

    // One clock: drive, check at the falling edge, advance the model to the next rising edge.
    task automatic cycle();
        int  win;
        bit  vis, ce;
        drive();
        @(negedge clk);
        vis = (q.size() > 0) && (q[0].age == LAT);
        ce  = !(vis && !bus.rsp_ready);
        win = -1;
        if (ce) begin
            for (int off = 0; off < N; off++) begin
                automatic int j = (ptr + off) % N;
                if (win < 0 && pend[j]) win = j;
            end
        end
        chk("mul_ce", 32'(bus.mul_ce), 32'(ce));
        chk("req_ready", 32'(bus.req_ready), (win < 0) ? 0 : (1 << win));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(vis));
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
        if (vis) begin
            chk("rsp_id", 32'(bus.rsp_id), q[0].id);
            chk("rsp_data", 32'(bus.rsp_data), q[0].p);
        end
        if (win >= 0) begin
            chk("mul_din0", 32'(bus.mul_din0), opa[win]);
            chk("mul_din1", 32'(bus.mul_din1), opb[win]);
        end
        if (bus.rsp_valid && !bus.rsp_ready) stalls++;
        if (bus.rsp_valid && bus.rsp_ready)
            rsp_log.push_back(log_t'{int'(bus.rsp_id), int'(bus.rsp_data), cyc});
        if (ce) begin
            if (vis) void'(q.pop_front());
            foreach (q[k]) q[k].age++;
            if (win >= 0) begin
                q.push_back(op_t'{win, opa[win] * opb[win], 1});
                ptr       = (win + 1) % N;
                pend[win] = 1'b0;
                gnt_log.push_back(win);
                gnt_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q.delete();
        ptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; opa[i] = 0; opb[i] = 0; end
        bus.rsp_ready = 1'b1;
        drive();
        #2;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mul_ce", 32'(bus.mul_ce), 1);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_req_ready_idle", 32'(bus.req_ready), 0);
        bus.req_valid = 4'b0110;
        #1;
        chk("rst_req_ready_live", 32'(bus.req_ready), 32'h2);
        drive();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // single op from requester 2
        clear_logs();
        offer(2, 100, 200);
        repeat (6) cycle();
        chk("single_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1 && gnt_cyc.size() >= 1) begin
            chk("single_id", rsp_log[0].id, 2);
            chk("single_data", rsp_log[0].p, 20000);
            chk("single_latency", rsp_log[0].at - gnt_cyc[0], LAT);
        end

        // maximum operands
        clear_logs();
        offer(0, 8191, 16383);
        repeat (6) cycle();
        chk("max_count", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) chk("max_data", rsp_log[0].p, 134193153);

        // round robin, all requesters continuously valid
        do_reset();
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++) offer(i, i + 1, 10);
            cycle();
        end
        repeat (8) cycle();
        for (int k = 0; k < 8; k++)
            if (gnt_log.size() > k) chk("rr_grant", gnt_log[k], k % N);
            else chk("rr_grant_missing", gnt_log.size(), k + 1);
        for (int k = 0; k < 4; k++)
            if (rsp_log.size() > k) begin
                chk("rr_data", rsp_log[k].p, 10 * (k + 1));
                chk("rr_consecutive", rsp_log[k].at - rsp_log[0].at, k);
            end else chk("rr_rsp_missing", rsp_log.size(), k + 1);

        // backpressure with three ops in flight
        clear_logs();
        stalls = 0;
        bus.rsp_ready = 1'b0;
        offer(0, 11, 7); offer(1, 300, 1000); offer(2, 8191, 2);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) offer(3, 5, 5);
            cycle();
        end
        chk("bp_stalls", stalls, 5);
        chk("bp_none_early", rsp_log.size(), 0);
        bus.rsp_ready = 1'b1;
        repeat (8) cycle();
        chk("bp_count", rsp_log.size(), 4);
        if (rsp_log.size() >= 3) begin
            chk("bp_consec1", rsp_log[1].at - rsp_log[0].at, 1);
            chk("bp_consec2", rsp_log[2].at - rsp_log[0].at, 2);
        end

        // reset with two ops in flight
        clear_logs();
        offer(0, 3, 4); offer(1, 5, 6);
        repeat (3) cycle();
        chk("pre_reset_valid", 32'(bus.rsp_valid), 1);
        reset = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("async_busy", 32'(bus.busy), 0);
        q.delete();
        ptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_logs();
        for (int i = 0; i < N; i++) offer(i, 20 + i, 3);
        repeat (10) cycle();
        if (gnt_log.size() >= 1) chk("post_reset_first", gnt_log[0], 0);
        chk("post_reset_rsp_count", rsp_log.size(), 4);

        // sparse traffic from requester 3
        clear_logs();
        for (int k = 0; k < 5; k++) begin
            offer(3, $urandom_range(0, 8191), $urandom_range(0, 16383));
            repeat (4) cycle();
        end
        chk("sparse_count", rsp_log.size(), 5);
        for (int k = 0; k < 5; k++)
            if (rsp_log.size() > k && gnt_cyc.size() > k) begin
                chk("sparse_on_arrival", gnt_cyc[k], gnt_cyc[0] + 4 * k);
                chk("sparse_latency", rsp_log[k].at - gnt_cyc[k], LAT);
                chk("sparse_id", rsp_log[k].id, 3);
            end

        // random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0)
                    offer(i, $urandom_range(0, 8191), $urandom_range(0, 16383));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        repeat (20) cycle();
        chk("drain_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
